multi_channel_water_dispenser: RTL
==================================

Name: multi_channel_water_dispenser

Overview:
Parametrised successor to the single-outlet timed dispenser. It provides NUM_CH independent outlets, each with a per-request dispense time, pause/resume and manual stop. A shared pump-capacity limit (MAX_ACTIVE) and a tank-empty interlock govern all outlets. It sits between the user-panel debouncers and the valve/pump drivers.

Parameters:
NUM_CH, 4, number of outlets (1..8)
TIMER_W, 8, width of each per-channel countdown timer
DEFAULT_TIME, 10, load value used when a request's dispense_time slice is 0
MAX_ACTIVE, 2, maximum channels simultaneously in RUN or HOLD (1..NUM_CH)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  NUM_CH  per-channel dispense request, sampled each clock
stop  in  NUM_CH  per-channel manual stop
pause  in  NUM_CH  per-channel pause level (high = hold)
dispense_time  in  NUM_CH*TIMER_W  per-channel load value, channel i at bits [i*TIMER_W +: TIMER_W]
tank_empty  in  1  tank interlock level
timer  out  NUM_CH*TIMER_W  per-channel remaining count, same packing
water_flow  out  NUM_CH  valve open
dispense_active  out  NUM_CH  channel in RUN or HOLD
done  out  NUM_CH  1-cycle pulse on timed completion
reject  out  NUM_CH  1-cycle pulse when a start from IDLE is refused
active_count  out  $clog2(NUM_CH+1)  number of channels in RUN or HOLD
flow_cycles  out  16  dispensed-cycle counter (see Optional Feature)

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high on port reset. All outputs are registered.
- Reset: all channels IDLE; timer=0, water_flow=0, dispense_active=0, done=0, reject=0, active_count=0, flow_cycles=0. Reset asserted mid-dispense closes all valves on the reset edge.
- Per-channel FSM states: IDLE, RUN, HOLD. dispense_active=1 in RUN/HOLD. water_flow=1 only in RUN.
- Load value: dispense_time slice if nonzero, else DEFAULT_TIME (truncated to TIMER_W).
- IDLE, start=1 and stop=0:
  - Granted if tank_empty=0 and (registered active_count + grants to lower-index channels this cycle) < MAX_ACTIVE. Lower index wins ties.
  - Grant: next state RUN, timer=load value.
  - Refused: stays IDLE, reject=1 for one cycle.
- IDLE, start=1 and stop=1: stays IDLE, no reject.
- RUN, evaluated in priority order:
  1. stop: go to IDLE, timer=0, no done.
  2. start: retrigger; reload timer, stay RUN. No capacity check.
  3. tank_empty or pause: go to HOLD, timer frozen.
  4. timer==1: timer=0, go to IDLE, done=1.
  5. Otherwise timer decrements.
- RUN timing: water_flow is high for exactly N cycles for load value N, absent pause or stop.
- HOLD:
  - stop: go to IDLE, timer=0.
  - start: reload timer, remain HOLD.
  - pause=0 and tank_empty=0: resume to RUN the next cycle with the frozen timer. HOLD cycles do not decrement.
- active_count updates on the same edge as the state change.
- Capacity: a channel leaving RUN/HOLD frees its slot only from the following cycle.
- No wrap-around: the timer never decrements below 0.

Optional Feature:
Macro: FLOW_COUNTER_EN.
- Defined: flow_cycles increments once per clock in which any water_flow bit is high, saturates at 16'hFFFF, and clears only on reset.
- Undefined: no counter logic is compiled and flow_cycles is tied to 0.

Test Plan:
- Single timed dispense: ch0 start with dispense_time=5 -> water_flow[0] high 5 cycles, timer 5,4,3,2,1,0, done[0] pulses on the closing edge, active_count 1 then 0.
- Zero load uses default: ch1 dispense_time=0, DEFAULT_TIME=10 -> flow high 10 cycles.
- Capacity and arbitration: ch0..ch2 start in the same cycle with MAX_ACTIVE=2 -> ch0 and ch1 granted, reject[2]=1 for 1 cycle; after ch0 done, ch2 start the next cycle is granted.
- Pause/tank interlock: ch0 time=8, pause at timer=5 for 3 cycles -> flow=0 and timer held at 5. On release, flow resumes with 5 cycles remaining. tank_empty=1 mid-run -> HOLD; a new start while tank_empty=1 -> reject.
- Stop and retrigger: stop at timer=3 -> IDLE, no done. Start at timer=2 -> timer reloads to the load value. Start and stop together in IDLE -> no action.
- Reset mid-operation, with FLOW_COUNTER_EN both defined and undefined: assert reset during 2 active runs -> all outputs 0 immediately. flow_cycles equals the total flow cycles when defined, and stays 0 when undefined.

Source files
------------

// File: rtl/multi_channel_water_dispenser_if.sv
// multi_channel_water_dispenser_if: user-panel and valve/pump bundle for the multi-channel dispenser
// master drives start/stop/pause/dispense_time/tank_empty; slave (the dispenser) drives
// timer/water_flow/dispense_active/done/reject/active_count/flow_cycles.
interface multi_channel_water_dispenser_if #(
  parameter int NUM_CH  = 4,
  parameter int TIMER_W = 8
);
  localparam int CW = $clog2(NUM_CH + 1);
  logic [NUM_CH-1:0]         start;
  logic [NUM_CH-1:0]         stop;
  logic [NUM_CH-1:0]         pause;
  logic [NUM_CH*TIMER_W-1:0] dispense_time;
  logic                      tank_empty;
  logic [NUM_CH*TIMER_W-1:0] timer;
  logic [NUM_CH-1:0]         water_flow;
  logic [NUM_CH-1:0]         dispense_active;
  logic [NUM_CH-1:0]         done;
  logic [NUM_CH-1:0]         reject;
  logic [CW-1:0]             active_count;
  logic [15:0]               flow_cycles;
  modport master (
    output start, stop, pause, dispense_time, tank_empty,
    input  timer, water_flow, dispense_active, done, reject, active_count, flow_cycles
  );
  modport slave (
    input  start, stop, pause, dispense_time, tank_empty,
    output timer, water_flow, dispense_active, done, reject, active_count, flow_cycles
  );
endinterface

// File: rtl/multi_channel_water_dispenser.sv
// multi_channel_water_dispenser: NUM_CH timed outlets sharing a MAX_ACTIVE pump budget and a tank interlock
// Ports: clk, reset (async, active-high), bus (slave modport: per-channel start/stop/pause/
// dispense_time and tank_empty in; timer/water_flow/dispense_active/done/reject/active_count/flow_cycles out).
// Optional: FLOW_COUNTER_EN compiles the saturating flow_cycles counter; otherwise it is tied to 0.
module multi_channel_water_dispenser #(
  parameter int NUM_CH       = 4,
  parameter int TIMER_W      = 8,
  parameter int DEFAULT_TIME = 10,
  parameter int MAX_ACTIVE   = 2
) (
  input logic clk,
  input logic reset,
  multi_channel_water_dispenser_if.slave bus
);
  localparam int CW = $clog2(NUM_CH + 1);
  localparam logic [TIMER_W-1:0] DEF = TIMER_W'(DEFAULT_TIME);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t             state [NUM_CH];
  state_t             state_n [NUM_CH];
  logic [TIMER_W-1:0] tmr [NUM_CH];
  logic [TIMER_W-1:0] tmr_n [NUM_CH];
  logic [TIMER_W-1:0] ld [NUM_CH];
  logic [NUM_CH-1:0]  done_n, reject_n, flow_n, act_n;
  logic [CW-1:0]      grants, cnt_n;
  always_comb begin
    grants   = '0;
    cnt_n    = '0;
    done_n   = '0;
    reject_n = '0;
    flow_n   = '0;
    act_n    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_n[i] = state[i];
      tmr_n[i]   = tmr[i];
      ld[i]      = |bus.dispense_time[i*TIMER_W +: TIMER_W] ? bus.dispense_time[i*TIMER_W +: TIMER_W] : DEF;
      case (state[i])
        IDLE:
          if (bus.start[i] && !bus.stop[i]) begin
            // budget uses the registered count, so slots freed this edge are visible only next cycle
            if (!bus.tank_empty && (({1'b0, bus.active_count} + {1'b0, grants}) < (CW+1)'(MAX_ACTIVE))) begin
              state_n[i] = RUN;
              tmr_n[i]   = ld[i];
              grants     = grants + 1'b1;
            end else
              reject_n[i] = 1'b1;
          end
        RUN:
          if (bus.stop[i]) begin
            state_n[i] = IDLE;
            tmr_n[i]   = '0;
          end else if (bus.start[i])
            tmr_n[i] = ld[i];
          else if (bus.tank_empty || bus.pause[i])
            state_n[i] = HOLD;
          else if (tmr[i] <= 1) begin
            state_n[i] = IDLE;
            tmr_n[i]   = '0;
            done_n[i]  = 1'b1;
          end else
            tmr_n[i] = tmr[i] - 1'b1;
        HOLD:
          if (bus.stop[i]) begin
            state_n[i] = IDLE;
            tmr_n[i]   = '0;
          end else if (bus.start[i])
            tmr_n[i] = ld[i];
          else if (!bus.pause[i] && !bus.tank_empty)
            state_n[i] = RUN;
        default: begin
          state_n[i] = IDLE;
          tmr_n[i]   = '0;
        end
      endcase
      flow_n[i] = state_n[i] == RUN;
      act_n[i]  = state_n[i] != IDLE;
      cnt_n     = cnt_n + CW'(act_n[i]);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= IDLE;
        tmr[i]   <= '0;
      end
      bus.water_flow      <= '0;
      bus.dispense_active <= '0;
      bus.done            <= '0;
      bus.reject          <= '0;
      bus.active_count    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= state_n[i];
        tmr[i]   <= tmr_n[i];
      end
      bus.water_flow      <= flow_n;
      bus.dispense_active <= act_n;
      bus.done            <= done_n;
      bus.reject          <= reject_n;
      bus.active_count    <= cnt_n;
    end
  end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_timer
    assign bus.timer[k*TIMER_W +: TIMER_W] = tmr[k];
  end
`ifdef FLOW_COUNTER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bus.flow_cycles <= '0;
    else if (|bus.water_flow && bus.flow_cycles != 16'hFFFF)
      bus.flow_cycles <= bus.flow_cycles + 16'd1;
  end
`else
  assign bus.flow_cycles = '0;
`endif
endmodule
